adc_init_seq: RTL

Parametrised power-up and re-initialisation sequencer for the AGC DAC and NCH ADC channel interfaces. It replaces the free-running start-up logic in the top level. After reset it loads the AGC word, then loads each ADC control word in turn, waiting for that channel's mbusy to clear. After a programmable settle delay it enables all channels. It can be re-armed at run time by a start pulse with new words.

---
 rtl/adc_init_seq_pkg.sv | 13 +
 rtl/adc_init_seq_delay_cnt.sv | 22 ++
 rtl/adc_init_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adc_init_seq_pkg.sv
// adc_init_seq_pkg: state encoding, reset defaults and wait constants shared by adc_init_seq
package adc_init_seq_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD_AGC  = 3'd1;
  localparam state_t ST_LOAD_ADC  = 3'd2;
  localparam state_t ST_WAIT_BUSY = 3'd3;
  localparam state_t ST_DELAY     = 3'd4;
  localparam state_t ST_RUN       = 3'd5;
  localparam logic [15:0] AGC_RST_DEF  = 16'h5555;
  localparam logic [9:0]  CTRL_RST_DEF = 10'b1010101010;
  localparam int WAIT_MIN = 2;
endpackage

// File: rtl/adc_init_seq_delay_cnt.sv
// seq_delay_cnt: loadable down-counter; tc_o pulses in the LEN-th enabled cycle after a load
module seq_delay_cnt
  import adc_init_seq_pkg::*;
#(
  parameter int LEN = 256
) (
  input  logic clk,
  input  logic arstn,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(LEN + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // Load LEN-1, then count down and hold at zero so the count never wraps
  always_comb cnt_d = load_i ? W'(LEN - 1) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // Counter register
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc_o = en_i && cnt_q == '0;
endmodule

// File: rtl/adc_init_seq.sv
// adc_init_seq: AGC/ADC power-up and re-init sequencer; define ADC_INIT_SEQ_TIMEOUT_EN for mbusy timeouts
module adc_init_seq
  import adc_init_seq_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CTRL_W = 10,
  parameter int DAC_W = 16,
  parameter int EN_DELAY = 256,
  parameter int TIMEOUT = 1024,
  parameter logic [DAC_W-1:0] AGC_RST = AGC_RST_DEF,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_RST_DEF
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  start,
  input  logic [DAC_W-1:0]      agc_word,
  input  logic [NCH*CTRL_W-1:0] ctrl_word,
  input  logic [NCH-1:0]        adc_mbusy,
  output logic [DAC_W-1:0]      agc_data,
  output logic                  agc_load,
  output logic [NCH*CTRL_W-1:0] adc_ctrlword,
  output logic [NCH-1:0]        adc_ldctrl,
  output logic [NCH-1:0]        adc_enable,
  output logic                  busy,
  output logic                  done,
  output logic [NCH-1:0]        err,
  output logic [31:0]           event_cnt
);
  localparam int CH_W = NCH > 1 ? $clog2(NCH) : 1;
  localparam int WMAX = TIMEOUT > WAIT_MIN ? TIMEOUT : WAIT_MIN;
  localparam int WW = $clog2(WMAX + 1);
  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [DAC_W-1:0] agc_q, agc_d;
  logic [NCH*CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [NCH-1:0] en_q, en_d, err_q, ld_q;
  logic agc_ld_q, busy_q, done_q;
  logic [31:0] event_cnt_q;
  logic wait_ok, last_ch, mbusy_ch, tmo_tc, exit_w, dly_tc;
  assign mbusy_ch = adc_mbusy[ch_q];
  assign wait_ok = wait_q == WW'(WAIT_MIN);
  assign last_ch = ch_q == CH_W'(NCH - 1);
  assign exit_w = state_q == ST_WAIT_BUSY && ((wait_ok && !mbusy_ch) || tmo_tc);
  seq_delay_cnt #(.LEN(EN_DELAY)) u_dly (
    .clk, .arstn, .load_i(exit_w && last_ch), .en_i(state_q == ST_DELAY), .tc_o(dly_tc)
  );
`ifdef ADC_INIT_SEQ_TIMEOUT_EN
  logic [NCH-1:0] err_d;
  seq_delay_cnt #(.LEN(TIMEOUT)) u_tmo (
    .clk, .arstn, .load_i(state_q == ST_LOAD_ADC), .en_i(state_q == ST_WAIT_BUSY), .tc_o(tmo_tc)
  );
  // A channel leaving WAIT_BUSY while still busy has timed out; flags stick until a re-init
  always_comb begin
    err_d = err_q;
    if (state_q == ST_RUN && start) err_d = '0;
    else if (exit_w && mbusy_ch) err_d[ch_q] = 1'b1;
  end
  // Timeout flag register
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) err_q <= '0;
    else err_q <= err_d;
`else
  assign tmo_tc = 1'b0;
  assign err_q = '0;
`endif
  // Sequencer next state: one AGC load, then per-channel load and busy wait, settle, run
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    wait_d = wait_q;
    agc_d = agc_q;
    ctrl_d = ctrl_q;
    en_d = en_q;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD_AGC;
      ST_LOAD_AGC: begin
        state_d = ST_LOAD_ADC;
        ch_d = '0;
      end
      ST_LOAD_ADC: begin
        state_d = ST_WAIT_BUSY;
        wait_d = '0;
      end
      ST_WAIT_BUSY: begin
        wait_d = wait_ok ? wait_q : wait_q + WW'(1);
        state_d = !exit_w ? state_q : last_ch ? ST_DELAY : ST_LOAD_ADC;
        ch_d = exit_w && !last_ch ? ch_q + CH_W'(1) : ch_q;
      end
      ST_DELAY: begin
        state_d = dly_tc ? ST_RUN : state_q;
        en_d = dly_tc ? ~err_q : en_q;
      end
      ST_RUN: if (start) begin
        state_d = ST_LOAD_AGC;
        agc_d = agc_word;
        ctrl_d = ctrl_word;
        en_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // State, data and registered output strobes derived from the next state
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      state_q <= ST_IDLE;
      ch_q <= '0;
      wait_q <= '0;
      agc_q <= AGC_RST;
      ctrl_q <= {NCH{CTRL_RST}};
      en_q <= '0;
      ld_q <= '0;
      agc_ld_q <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      wait_q <= wait_d;
      agc_q <= agc_d;
      ctrl_q <= ctrl_d;
      en_q <= en_d;
      ld_q <= state_d == ST_LOAD_ADC ? NCH'(1) << ch_d : '0;
      agc_ld_q <= state_d == ST_LOAD_AGC;
      busy_q <= state_d != ST_RUN;
      done_q <= state_d == ST_RUN;
      event_cnt_q <= event_cnt_q + 32'd1;
    end
  assign agc_data = agc_q;
  assign agc_load = agc_ld_q;
  assign adc_ctrlword = ctrl_q;
  assign adc_ldctrl = ld_q;
  assign adc_enable = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign event_cnt = event_cnt_q;
endmodule
